// File: rtl/mux_nto1_hs.sv
// ============================================================================
// Module   : mux_nto1_hs
// Brief    : Registered N-to-1 multiplexer with valid/ready handshakes.
//            A request is captured in IDLE, forwarded in MUX and held in DONE
//            until the downstream accepts it.
// Config   : define MUX_SEL_RANGE_CHK_EN to build the out-of-range flag o_err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_nto1_hs #(
    parameter int WIDTH  = 4,
    parameter int NUM_IN = 4,
    localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]        i_sel,
    input  logic                    i_vld,
    output logic                    i_rdy,
    output logic [WIDTH-1:0]        y,
    output logic                    o_vld,
    input  logic                    o_rdy,
    output logic                    o_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUX  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [NUM_IN*WIDTH-1:0] r_data;
    logic [SEL_W-1:0]        r_sel;
    logic [WIDTH-1:0]        r_y;
    logic                    r_vld;
    logic [WIDTH-1:0]        w_mux;
    logic                    w_accept;

    assign w_accept = (r_state == S_IDLE) && i_vld;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; the unused encoding falls back to IDLE
    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_nxt = i_vld ? S_MUX : S_IDLE;
            S_MUX:   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = o_rdy ? S_IDLE : S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_sel  <= '0;
        end else if (w_accept) begin
            r_data <= i_data;
            r_sel  <= i_sel;
        end
    end

    // Selects with no matching input leave the result at zero
    always_comb begin
        w_mux = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(r_sel) == k) begin
                w_mux = r_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y   <= '0;
            r_vld <= 1'b0;
        end else begin
            case (r_state)
                S_MUX: begin
                    r_y   <= w_mux;
                    r_vld <= 1'b1;
                end
                S_DONE: begin
                    if (o_rdy) begin
                        r_vld <= 1'b0;
                    end
                end
                default: begin
                    r_vld <= r_vld;
                end
            endcase
        end
    end

`ifdef MUX_SEL_RANGE_CHK_EN
    localparam logic [SEL_W:0] c_num_in = (SEL_W+1)'(NUM_IN);

    logic r_err;
    logic w_out_of_range;

    assign w_out_of_range = ({1'b0, r_sel} >= c_num_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (r_state == S_MUX) begin
            r_err <= w_out_of_range;
        end else if ((r_state == S_DONE) && o_rdy) begin
            r_err <= 1'b0;
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    assign i_rdy = (r_state == S_IDLE);
    assign y     = r_y;
    assign o_vld = r_vld;

endmodule

`default_nettype wire

// File: tb/tb_mux_nto1_hs.sv
// ============================================================================
// Module   : tb_mux_nto1_hs
// Brief    : Self-checking bench for mux_nto1_hs (4x4, 5x8 and 1x4 instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_nto1_hs;

`ifdef MUX_SEL_RANGE_CHK_EN
    localparam logic c_chk = 1'b1;
`else
    localparam logic c_chk = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vld = 1'b0;
    logic ordy = 1'b0;

    logic [15:0] data4 = '0;
    logic [1:0]  sel4  = '0;
    logic [39:0] data5 = '0;
    logic [2:0]  sel5  = '0;
    logic [3:0]  data1 = '0;
    logic [0:0]  sel1  = '0;

    logic       rdy4, vld4, err4;
    logic [3:0] y4;
    logic       rdy5, vld5, err5;
    logic [7:0] y5;
    logic       rdy1, vld1, err1;
    logic [3:0] y1;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mux_nto1_hs #(.WIDTH(4), .NUM_IN(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .i_data(data4), .i_sel(sel4), .i_vld(vld),
        .i_rdy(rdy4), .y(y4), .o_vld(vld4), .o_rdy(ordy), .o_err(err4));

    mux_nto1_hs #(.WIDTH(8), .NUM_IN(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .i_data(data5), .i_sel(sel5), .i_vld(vld),
        .i_rdy(rdy5), .y(y5), .o_vld(vld5), .o_rdy(ordy), .o_err(err5));

    mux_nto1_hs #(.WIDTH(4), .NUM_IN(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_data(data1), .i_sel(sel1), .i_vld(vld),
        .i_rdy(rdy1), .y(y1), .o_vld(vld1), .o_rdy(ordy), .o_err(err1));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding request per instance.
    function automatic logic [31:0] pick(input logic [127:0] d, input int s, input int n, input int w);
        logic [127:0] t;
        if (s >= n) return 32'd0;
        t = d >> (s * w);
        return t[31:0] & ((32'd1 << w) - 32'd1);
    endfunction

    logic        m_busy [3];
    logic        m_pend [3];
    logic        m_vld  [3];
    logic        m_err  [3];
    logic        m_nerr [3];
    logic [31:0] m_y    [3];
    logic [31:0] m_next [3];
    logic [127:0] m_dd;
    int          m_ss, m_nn, m_ww;

    initial begin
        for (int d = 0; d < 3; d++) begin
            m_busy[d] = 0; m_pend[d] = 0; m_vld[d] = 0; m_err[d] = 0;
            m_nerr[d] = 0; m_y[d] = 0; m_next[d] = 0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) begin
                m_busy[d] = 0; m_pend[d] = 0; m_vld[d] = 0; m_err[d] = 0;
                m_y[d] = 0; m_next[d] = 0; m_nerr[d] = 0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                case (d)
                    0: begin m_dd = 128'(data4); m_ss = int'(sel4); m_nn = 4; m_ww = 4; end
                    1: begin m_dd = 128'(data5); m_ss = int'(sel5); m_nn = 5; m_ww = 8; end
                    default: begin m_dd = 128'(data1); m_ss = int'(sel1); m_nn = 1; m_ww = 4; end
                endcase
                if (!m_busy[d]) begin
                    if (vld) begin
                        m_next[d] = pick(m_dd, m_ss, m_nn, m_ww);
                        m_nerr[d] = c_chk && (m_ss >= m_nn);
                        m_busy[d] = 1;
                        m_pend[d] = 1;
                    end
                end else if (m_pend[d]) begin
                    m_y[d]    = m_next[d];
                    m_err[d]  = m_nerr[d];
                    m_vld[d]  = 1;
                    m_pend[d] = 0;
                end else if (ordy) begin
                    m_vld[d]  = 0;
                    m_err[d]  = 0;
                    m_busy[d] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("dut4.i_rdy", 32'(rdy4), 32'(!m_busy[0]));
        check("dut4.o_vld", 32'(vld4), 32'(m_vld[0]));
        check("dut4.y",     32'(y4),   m_y[0]);
        check("dut4.o_err", 32'(err4), 32'(m_err[0]));
        check("dut5.i_rdy", 32'(rdy5), 32'(!m_busy[1]));
        check("dut5.o_vld", 32'(vld5), 32'(m_vld[1]));
        check("dut5.y",     32'(y5),   m_y[1]);
        check("dut5.o_err", 32'(err5), 32'(m_err[1]));
        check("dut1.i_rdy", 32'(rdy1), 32'(!m_busy[2]));
        check("dut1.o_vld", 32'(vld1), 32'(m_vld[2]));
        check("dut1.y",     32'(y1),   m_y[2]);
        check("dut1.o_err", 32'(err1), 32'(m_err[2]));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (!rdy4 && n < 10) begin
            tick();
            n++;
        end
        if (!rdy4) begin
            miscompares++;
            $display("FAIL wait_rdy: i_rdy stayed 0 for %0d cycles, expected 1", n);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [3:0] exp_b2b [4];
    logic [2:0] s5_tab  [4];
    logic [7:0] y5_tab  [4];
    logic       oor5    [4];
    logic [0:0] s1_tab  [4];
    logic [3:0] y1_tab  [4];
    int acc_cyc, prev_cyc;

    initial begin
        exp_b2b = '{4'hA, 4'hB, 4'hC, 4'hD};
        s5_tab  = '{3'd4, 3'd5, 3'd6, 3'd0};
        y5_tab  = '{8'h55, 8'h00, 8'h00, 8'h11};
        oor5    = '{1'b0, 1'b1, 1'b1, 1'b0};
        s1_tab  = '{1'b0, 1'b1, 1'b1, 1'b0};
        y1_tab  = '{4'h9, 4'h0, 4'h0, 4'h9};
        prev_cyc = 0;

        // Reset: ready reads 1 while held, outputs cleared
        repeat (3) tick();
        check("rst.i_rdy", 32'(rdy4), 32'd1);
        check("rst.o_vld", 32'(vld4), 32'd0);
        check("rst.y",     32'(y4),   32'd0);
        check("rst.o_err", 32'(err4), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single transfer, sel=2
        data4 = 16'hDCBA; sel4 = 2'd2; vld = 1'b1; ordy = 1'b1;
        tick();
        vld = 1'b0;
        check("single.i_rdy_busy", 32'(rdy4), 32'd0);
        tick();
        check("single.y",     32'(y4),   32'hC);
        check("single.o_vld", 32'(vld4), 32'd1);
        tick();
        check("single.o_vld_drop", 32'(vld4), 32'd0);
        check("single.i_rdy_back", 32'(rdy4), 32'd1);

        // Backpressure with ignored requests
        sel4 = 2'd1; vld = 1'b1; ordy = 1'b0;
        tick();
        vld = 1'b0;
        tick();
        check("bp.o_vld_rise", 32'(vld4), 32'd1);
        for (int i = 0; i < 5; i++) begin
            vld = 1'b1; sel4 = 2'd3;
            tick();
            check("bp.y_hold",   32'(y4),   32'hB);
            check("bp.vld_hold", 32'(vld4), 32'd1);
            check("bp.i_rdy",    32'(rdy4), 32'd0);
        end
        vld = 1'b0; ordy = 1'b1;
        tick();
        check("bp.o_vld_done", 32'(vld4), 32'd0);
        check("bp.y_retain",   32'(y4),   32'hB);
        check("bp.i_rdy_back", 32'(rdy4), 32'd1);
        tick();

        // Back-to-back with i_vld held high
        vld = 1'b1; ordy = 1'b1;
        for (int s = 0; s < 4; s++) begin
            wait_rdy();
            sel4 = 2'(s);
            acc_cyc = cyc;
            if (s > 0) check("b2b.gap", 32'(acc_cyc - prev_cyc), 32'd3);
            prev_cyc = acc_cyc;
            tick();
            tick();
            check("b2b.y", 32'(y4), 32'(exp_b2b[s]));
        end
        vld = 1'b0;
        repeat (2) tick();

        // Range boundaries on the 5-input and 1-input instances
        data5 = 40'h55_44_33_22_11; data1 = 4'h9;
        for (int i = 0; i < 4; i++) begin
            sel5 = s5_tab[i]; sel1 = s1_tab[i]; vld = 1'b1; ordy = 1'b1;
            tick();
            vld = 1'b0;
            tick();
            check("range.o_vld5", 32'(vld5), 32'd1);
            check("range.y5",     32'(y5),   32'(y5_tab[i]));
            check("range.o_err5", 32'(err5), 32'(oor5[i] & c_chk));
            check("range.y1",     32'(y1),   32'(y1_tab[i]));
            check("range.o_err1", 32'(err1), 32'(s1_tab[i][0] & c_chk));
            repeat (2) tick();
        end

        // Reset while held in DONE
        sel4 = 2'd3; vld = 1'b1; ordy = 1'b0;
        tick();
        vld = 1'b0;
        tick();
        tick();
        check("abort.pre_vld", 32'(vld4), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("abort.y",     32'(y4),   32'd0);
        check("abort.o_vld", 32'(vld4), 32'd0);
        check("abort.i_rdy", 32'(rdy4), 32'd1);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("abort.no_pulse", 32'(vld4), 32'd0);
        sel4 = 2'd0; vld = 1'b1; ordy = 1'b1;
        tick();
        vld = 1'b0;
        tick();
        check("abort.next_y", 32'(y4), 32'hA);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
